exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage LoongArch pipeline, between ID and MEM. Latches the ID pipeline bundle, computes the ALU, multiply or iterative-divide result, and issues the data-SRAM request for loads and stores. Publishes a forwarding bundle back to ID, including a not-ready flag that stalls dependent instructions. Implements the valid/allow_in handshake with both neighbouring stages.

## Interface

- No parameters.
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `ID_EXE_valid`  in  1  ID offers an instruction
- `EXE_allow_in`  out  1  EXE accepts an instruction this cycle
- `ID_pc`  in  32  PC of the offered instruction
- `ID_alu`  in  83  {alu_op[82:64], alu_src2[63:32], alu_src1[31:0]}
- `ID_mem`  in  34  {mem_we[33], res_from_mem[32], rkd_value[31:0]}
- `ID_rf`  in  6  {rf_we[5], rf_waddr[4:0]}
- `ID_inst`  in  8  {st_h, st_b, st_w, ld_hu, ld_bu, ld_h, ld_b, ld_w}
- `MEM_allow_in`  in  1  MEM accepts an instruction
- `EXE_MEM_valid`  out  1  EXE offers an instruction to MEM
- `EXE_pc`  out  32  PC of the EXE instruction
- `EXE_to_MEM`  out  44  {ld_hu, ld_bu, ld_h, ld_b, ld_w[43:39], res_from_mem[38], rf_we[37], rf_waddr[36:32], result[31:0]}
- `EXE_rf`  out  39  forwarding bundle {not_ready[38], we[37], waddr[36:32], wdata[31:0]}
- `data_sram_en`  out  1  data-SRAM access enable
- `data_sram_we`  out  4  byte write enables
- `data_sram_addr`  out  32  byte address (= result)
- `data_sram_wdata`  out  32  store data

## Operation

- Input capture: when `ID_EXE_valid & EXE_allow_in`, all ID inputs are latched; the captured `EXE_valid` is cleared on `rst`, otherwise it loads `ID_EXE_valid` whenever `EXE_allow_in` is high.
- Handshake: `EXE_allow_in = ~EXE_valid | (ready_go & MEM_allow_in)`; `EXE_MEM_valid = EXE_valid & ready_go`. `ready_go = 1` except for a divide op that is not in state DONE.
- ALU ops, single-cycle (one-hot alu_op):
  - 0 add, 1 sub, 2 slt (signed), 3 sltu, 4 and, 5 nor, 6 or, 7 xor.
  - 8 sll, 9 srl, 10 sra; the shift amount is src2[4:0].
  - 11 lu12i: result = src2.
  - 12 mul.w: low 32 bits of the product; 13 mulh.w: high 32 bits, signed; 14 mulh.wu: high 32 bits, unsigned. Multiplies are combinational on 33-bit sign/zero-extended operands.
- Divider ops: 15 div.w, 16 div.wu, 17 mod.w, 18 mod.wu. The divider is iterative restoring, one quotient bit per cycle, on the operand magnitudes.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0, any variant: quotient = 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / 0xFFFFFFFF signed: quotient = 0x80000000, remainder = 0.
- Divider FSM:
  - IDLE → BUSY when `EXE_valid` and a divide op is present; operands are latched and the count is cleared.
  - BUSY: 32 iterations, then → DONE.
  - DONE → IDLE when `MEM_allow_in` (the instruction leaves EXE).
  - `rst` forces IDLE, count 0.
- Memory requests:
  - `data_sram_en = EXE_valid & MEM_allow_in & (res_from_mem | mem_we)`.
  - Address = add result.
  - `data_sram_we` is 0 unless `mem_we`:
    - st.w: 4'b1111.
    - st.h: 4'b0011 << {addr[1], 1'b0}.
    - st.b: 4'b0001 << addr[1:0].
  - `data_sram_wdata`: st.b replicates byte rkd[7:0] ×4; st.h replicates halfword rkd[15:0] ×2; st.w uses rkd.
- Forwarding bundle:
  - `EXE_rf.we = EXE_valid & rf_we`.
  - `EXE_rf.wdata = result`.
  - `not_ready = res_from_mem | (divide op & state != DONE)`.

## Timing

- Reset values:
  - `EXE_valid = 0`, so `EXE_MEM_valid = 0` and `EXE_allow_in = 1`.
  - `data_sram_en = 0`, `data_sram_we = 0`, `EXE_rf.we = 0`, FSM IDLE.
  - Data registers (`EXE_pc`, result fields) are don't-care.
- Non-divide instructions: 1 cycle in EXE when `MEM_allow_in = 1`.
- Divide instructions: a divide accepted at edge E is valid during cycle T; BUSY covers T+1..T+32; DONE at T+33, where `EXE_MEM_valid = 1`. Minimum 34 cycles.
- MEM back-pressure:
  - Outputs hold and `data_sram_en = 0`, so no duplicate stores.
  - A divide stays in DONE and does not restart.
- A new instruction is captured in the same cycle the previous one leaves (back-to-back acceptance).
- Two consecutive divides: the second starts IDLE → BUSY on the cycle after it is captured.
- `rst` mid-divide: the divide is abandoned and the next cycle is empty.

## Test plan

- add.w, src1 = 0x7FFFFFFF, src2 = 1 → result 0x80000000, `EXE_MEM_valid` 1 cycle after capture, `EXE_rf` = {0, 1, rd, 0x80000000}.
- div.w −7/2 → quotient 0xFFFFFFFD; mod.w −7/2 → 0xFFFFFFFF.
  - `not_ready = 1` for 33 cycles, `EXE_MEM_valid` on the 34th cycle.
  - `EXE_allow_in = 0` throughout.
- div.wu 5/0 → 0xFFFFFFFF; mod.wu 5/0 → 5; div.w 0x80000000/−1 → 0x80000000.
- st.b, addr 0x1002, rkd 0x12345678 → `data_sram_we` = 4'b0100, `data_sram_wdata` = 0x78787878, `data_sram_en` = 1.
  - Repeat with `MEM_allow_in = 0` for 3 cycles → `data_sram_en` = 0 until accepted, exactly one write.
- mulh.wu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulh.w on the same operands → 0x00000000; mul.w → 0x00000001.
- Assert `rst` at BUSY count 10 → next cycle `EXE_valid` = 0 and FSM IDLE; a following add.w completes in 1 cycle.

Source files
------------

// File: rtl/exe_stage_if.sv
// Bundle of the ID->EXE, EXE->MEM/ID and data-SRAM signals around the execute stage.
// The slave modport is the execute stage; the master modport is its environment.
interface exe_stage_if;
  logic        ID_EXE_valid;
  logic        EXE_allow_in;
  logic [31:0] ID_pc;
  logic [82:0] ID_alu;
  logic [33:0] ID_mem;
  logic [5:0]  ID_rf;
  logic [7:0]  ID_inst;
  logic        MEM_allow_in;
  logic        EXE_MEM_valid;
  logic [31:0] EXE_pc;
  logic [43:0] EXE_to_MEM;
  logic [38:0] EXE_rf;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output ID_EXE_valid, ID_pc, ID_alu, ID_mem, ID_rf, ID_inst, MEM_allow_in,
    input  EXE_allow_in, EXE_MEM_valid, EXE_pc, EXE_to_MEM, EXE_rf,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ID_EXE_valid, ID_pc, ID_alu, ID_mem, ID_rf, ID_inst, MEM_allow_in,
    output EXE_allow_in, EXE_MEM_valid, EXE_pc, EXE_to_MEM, EXE_rf,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// LoongArch execute stage: ALU, combinational multiply, 32-cycle restoring divider,
// data-SRAM request generation and the forwarding bundle back to ID.
module exe_stage (
  input logic       clk,
  input logic       rst,
  exe_stage_if.slave bus
);
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        exe_valid_q;
  logic [31:0] pc_q, src1_q, src2_q, rkd_q;
  logic [18:0] alu_op_q;
  logic        mem_we_q, res_from_mem_q, rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [7:0]  inst_q;

  div_state_e  div_state_q;
  logic [4:0]  div_cnt_q;
  logic [31:0] div_rem_q, div_quo_q, div_dsor_q;
  logic        div_qneg_q, div_rneg_q, div_zero_q;

  logic        is_div, div_signed, ready_go, allow_in, not_ready;
  logic [31:0] result;

  assign is_div     = |alu_op_q[18:15];
  assign div_signed = alu_op_q[15] | alu_op_q[17];
  assign ready_go   = ~is_div | (div_state_q == DIV_DONE);
  assign allow_in   = ~exe_valid_q | (ready_go & bus.MEM_allow_in);

  // ---- ID -> EXE capture ----
  always_ff @(posedge clk) begin
    if (rst)
      exe_valid_q <= 1'b0;
    else if (allow_in)
      exe_valid_q <= bus.ID_EXE_valid;
  end

  always_ff @(posedge clk) begin
    if (allow_in && bus.ID_EXE_valid) begin
      pc_q           <= bus.ID_pc;
      alu_op_q       <= bus.ID_alu[82:64];
      src2_q         <= bus.ID_alu[63:32];
      src1_q         <= bus.ID_alu[31:0];
      mem_we_q       <= bus.ID_mem[33];
      res_from_mem_q <= bus.ID_mem[32];
      rkd_q          <= bus.ID_mem[31:0];
      rf_we_q        <= bus.ID_rf[5];
      rf_waddr_q     <= bus.ID_rf[4:0];
      inst_q         <= bus.ID_inst;
    end
  end

  // ---- EXE: single-cycle ALU and multiplier ----
  logic signed [31:0] src1_s, src2_s;
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic [4:0]         shamt;

  assign src1_s = src1_q;
  assign src2_s = src2_q;
  assign shamt  = src2_q[4:0];
  // Only mulh.w sign-extends; mul.w needs just the low word, which is extension-agnostic.
  assign mul_a  = $signed({{32{alu_op_q[13] & src1_q[31]}}, src1_q});
  assign mul_b  = $signed({{32{alu_op_q[13] & src2_q[31]}}, src2_q});
  assign mul_p  = mul_a * mul_b;

  // ---- EXE: iterative restoring divider on operand magnitudes ----
  logic [32:0] div_shift, div_trial;
  logic [31:0] div_q_res, div_r_res;

  assign div_shift = {div_rem_q, div_quo_q[31]};
  assign div_trial = div_shift - {1'b0, div_dsor_q};
  assign div_q_res = div_zero_q ? 32'hFFFF_FFFF : cond_neg(div_quo_q, div_qneg_q);
  assign div_r_res = cond_neg(div_rem_q, div_rneg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= 5'd0;
    end else begin
      unique case (div_state_q)
        DIV_IDLE: if (exe_valid_q && is_div) begin
          div_state_q <= DIV_BUSY;
          div_cnt_q   <= 5'd0;
        end
        DIV_BUSY: begin
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd31)
            div_state_q <= DIV_DONE;
        end
        DIV_DONE: if (bus.MEM_allow_in)
          div_state_q <= DIV_IDLE;
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (div_state_q == DIV_IDLE) begin
      div_rem_q  <= 32'd0;
      div_quo_q  <= cond_neg(src1_q, div_signed & src1_q[31]);
      div_dsor_q <= cond_neg(src2_q, div_signed & src2_q[31]);
      div_qneg_q <= div_signed & (src1_q[31] ^ src2_q[31]);
      div_rneg_q <= div_signed & src1_q[31];
      div_zero_q <= (src2_q == 32'd0);
    end else if (div_state_q == DIV_BUSY) begin
      if (!div_trial[32]) begin
        div_rem_q <= div_trial[31:0];
        div_quo_q <= {div_quo_q[30:0], 1'b1};
      end else begin
        div_rem_q <= div_shift[31:0];
        div_quo_q <= {div_quo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    result = 32'd0;
    if (alu_op_q[0])       result = src1_q + src2_q;
    else if (alu_op_q[1])  result = src1_q - src2_q;
    else if (alu_op_q[2])  result = {31'd0, src1_s < src2_s};
    else if (alu_op_q[3])  result = {31'd0, src1_q < src2_q};
    else if (alu_op_q[4])  result = src1_q & src2_q;
    else if (alu_op_q[5])  result = ~(src1_q | src2_q);
    else if (alu_op_q[6])  result = src1_q | src2_q;
    else if (alu_op_q[7])  result = src1_q ^ src2_q;
    else if (alu_op_q[8])  result = src1_q << shamt;
    else if (alu_op_q[9])  result = src1_q >> shamt;
    else if (alu_op_q[10]) result = src1_s >>> shamt;
    else if (alu_op_q[11]) result = src2_q;
    else if (alu_op_q[12]) result = mul_p[31:0];
    else if (alu_op_q[13] || alu_op_q[14]) result = mul_p[63:32];
    else if (alu_op_q[15] || alu_op_q[16]) result = div_q_res;
    else if (alu_op_q[17] || alu_op_q[18]) result = div_r_res;
  end

  // ---- EXE -> MEM / SRAM / forwarding ----
  always_comb begin
    bus.data_sram_we = 4'b0000;
    if (exe_valid_q && mem_we_q) begin
      if (inst_q[5])      bus.data_sram_we = 4'b1111;
      else if (inst_q[7]) bus.data_sram_we = 4'b0011 << {result[1], 1'b0};
      else if (inst_q[6]) bus.data_sram_we = 4'b0001 << result[1:0];
    end
  end

  assign bus.data_sram_wdata = inst_q[6] ? {4{rkd_q[7:0]}} :
                               inst_q[7] ? {2{rkd_q[15:0]}} : rkd_q;
  // Gating on MEM_allow_in keeps a stalled store from writing more than once.
  assign bus.data_sram_en    = exe_valid_q & bus.MEM_allow_in & (res_from_mem_q | mem_we_q);
  assign bus.data_sram_addr  = result;

  assign not_ready         = exe_valid_q & (res_from_mem_q | (is_div & (div_state_q != DIV_DONE)));
  assign bus.EXE_allow_in  = allow_in;
  assign bus.EXE_MEM_valid = exe_valid_q & ready_go;
  assign bus.EXE_pc        = pc_q;
  assign bus.EXE_to_MEM    = {inst_q[4:0], res_from_mem_q, rf_we_q, rf_waddr_q, result};
  assign bus.EXE_rf        = {not_ready, exe_valid_q & rf_we_q, rf_waddr_q, result};
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU/multiply vector table plus hand sequences for
// divides, stores under MEM back-pressure and reset in the middle of a divide.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  exe_stage_if bus();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic mem_we, input logic rfm, input logic [31:0] rkd,
                       input logic [5:0] rf, input logic [7:0] inst, input logic [31:0] pc);
    bus.ID_EXE_valid = 1'b1;
    bus.ID_pc        = pc;
    bus.ID_alu       = {(19'd1 << idx), b, a};
    bus.ID_mem       = {mem_we, rfm, rkd};
    bus.ID_rf        = rf;
    bus.ID_inst      = inst;
  endtask

  // Called at the first cycle a divide sits in EXE; returns in its DONE cycle.
  task automatic wait_div(input string name, input logic [31:0] exp);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (bus.EXE_MEM_valid !== 1'b1 && n < 40) begin
      if (bus.EXE_rf[38] !== 1'b1 || bus.EXE_allow_in !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd33);
    check({name, " stall"}, {63'd0, bad}, 64'd0);
    check({name, " result"}, {32'd0, bus.EXE_to_MEM[31:0]}, {32'd0, exp});
    check({name, " not_ready"}, {63'd0, bus.EXE_rf[38]}, 64'd0);
  endtask

  task automatic run_div(input string name, input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(idx, a, b, 1'b0, 1'b0, 32'd0, 6'h27, 8'd0, 32'h1C00_0100);
    tick();
    bus.ID_EXE_valid = 1'b0;
    wait_div(name, exp);
    tick();
    check({name, " leave"}, {63'd0, bus.EXE_MEM_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   writes;
    logic bad;

    vecs[0]  = '{0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add.w"};
    vecs[1]  = '{1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "sub.w"};
    vecs[2]  = '{2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt -1<1"};
    vecs[3]  = '{2,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt 1<-1"};
    vecs[4]  = '{3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu big<1"};
    vecs[5]  = '{3,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu 1<big"};
    vecs[6]  = '{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};
    vecs[7]  = '{5,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, "nor"};
    vecs[8]  = '{6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, "or"};
    vecs[9]  = '{7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor"};
    vecs[10] = '{8,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll amt5"};
    vecs[11] = '{9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srl"};
    vecs[12] = '{10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, "sra"};
    vecs[13] = '{11, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, "lu12i"};
    vecs[14] = '{12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul.w"};
    vecs[15] = '{13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh.w"};
    vecs[16] = '{14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulh.wu"};
    vecs[17] = '{13, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, "mulh.w neg"};
    vecs[18] = '{14, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, "mulh.wu 2^32"};

    rst              = 1'b1;
    bus.ID_EXE_valid = 1'b0;
    bus.ID_pc        = 32'd0;
    bus.ID_alu       = 83'd0;
    bus.ID_mem       = 34'd0;
    bus.ID_rf        = 6'd0;
    bus.ID_inst      = 8'd0;
    bus.MEM_allow_in = 1'b1;
    repeat (3) tick();

    check("rst EXE_MEM_valid", {63'd0, bus.EXE_MEM_valid}, 64'd0);
    check("rst EXE_allow_in", {63'd0, bus.EXE_allow_in}, 64'd1);
    check("rst sram_en", {63'd0, bus.data_sram_en}, 64'd0);
    check("rst sram_we", {60'd0, bus.data_sram_we}, 64'd0);
    check("rst rf_we", {63'd0, bus.EXE_rf[37]}, 64'd0);
    rst = 1'b0;
    tick();

    // Single-cycle ops issued back to back
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].idx, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 32'd0,
            {1'b1, 5'(i + 1)}, 8'd0, 32'h1C00_0000 + 32'(4 * i));
      tick();
      check({vecs[i].name, " valid"}, {63'd0, bus.EXE_MEM_valid}, 64'd1);
      check({vecs[i].name, " EXE_rf"}, {25'd0, bus.EXE_rf},
            {25'd0, 1'b0, 1'b1, 5'(i + 1), vecs[i].exp});
      if (i == 0)
        check("add.w pc", {32'd0, bus.EXE_pc}, 64'h1C00_0000);
    end
    bus.ID_EXE_valid = 1'b0;
    tick();
    check("table drain", {63'd0, bus.EXE_MEM_valid}, 64'd0);

    // Divides, including the divide-by-zero and overflow corners
    run_div("div.w -7/2",    15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_div("mod.w -7/2",    17, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_div("div.w 7/-2",    15, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_div("mod.w 7/-2",    17, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001);
    run_div("div.wu 5/0",    16, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_div("mod.wu 5/0",    18, 32'd5,         32'd0,         32'h0000_0005);
    run_div("div.w -7/0",    15, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_div("mod.w -7/0",    17, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_div("div.w min/-1",  15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod.w min/-1",  17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Divide held in DONE by MEM back-pressure
    bus.MEM_allow_in = 1'b0;
    drive(16, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 6'h21, 8'd0, 32'h1C00_0200);
    tick();
    bus.ID_EXE_valid = 1'b0;
    wait_div("div.wu 100/7 stalled", 32'd14);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.EXE_MEM_valid !== 1'b1 || bus.EXE_allow_in !== 1'b0 ||
          bus.EXE_to_MEM[31:0] !== 32'd14) bad = 1'b1;
    end
    check("div hold in DONE", {63'd0, bad}, 64'd0);
    bus.MEM_allow_in = 1'b1;
    tick();
    check("div hold leave", {63'd0, bus.EXE_MEM_valid}, 64'd0);

    // Two divides back to back; the second waits while the first iterates
    drive(16, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 6'h21, 8'd0, 32'h1C00_0300);
    tick();
    drive(15, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 32'd0, 6'h22, 8'd0, 32'h1C00_0304);
    wait_div("b2b first div.wu", 32'd14);
    tick();
    bus.ID_EXE_valid = 1'b0;
    check("b2b second pc", {32'd0, bus.EXE_pc}, 64'h1C00_0304);
    wait_div("b2b second div.w", 32'hFFFF_FFF2);
    tick();

    // Stores and a load
    drive(0, 32'h0000_1000, 32'd2, 1'b1, 1'b0, 32'h1234_5678, 6'd0, 8'b0100_0000, 32'h1C00_0400);
    tick();
    check("st.b en", {63'd0, bus.data_sram_en}, 64'd1);
    check("st.b we", {60'd0, bus.data_sram_we}, 64'h4);
    check("st.b wdata", {32'd0, bus.data_sram_wdata}, 64'h7878_7878);
    check("st.b addr", {32'd0, bus.data_sram_addr}, 64'h0000_1002);
    check("st.b rf_we", {63'd0, bus.EXE_rf[37]}, 64'd0);
    drive(0, 32'h0000_2000, 32'd2, 1'b1, 1'b0, 32'hAAAA_BEEF, 6'd0, 8'b1000_0000, 32'h1C00_0404);
    tick();
    check("st.h we", {60'd0, bus.data_sram_we}, 64'hC);
    check("st.h wdata", {32'd0, bus.data_sram_wdata}, 64'hBEEF_BEEF);
    drive(0, 32'h0000_3000, 32'd4, 1'b1, 1'b0, 32'hDEAD_BEEF, 6'd0, 8'b0010_0000, 32'h1C00_0408);
    tick();
    check("st.w we", {60'd0, bus.data_sram_we}, 64'hF);
    check("st.w wdata", {32'd0, bus.data_sram_wdata}, 64'hDEAD_BEEF);
    drive(0, 32'h0000_4000, 32'd1, 1'b0, 1'b1, 32'd0, {1'b1, 5'd9}, 8'b0000_0010, 32'h1C00_040C);
    tick();
    check("ld.b en", {63'd0, bus.data_sram_en}, 64'd1);
    check("ld.b we", {60'd0, bus.data_sram_we}, 64'h0);
    check("ld.b not_ready", {63'd0, bus.EXE_rf[38]}, 64'd1);
    check("ld.b EXE_to_MEM ctl", {52'd0, bus.EXE_to_MEM[43:32]}, {52'd0, 5'b00010, 1'b1, 1'b1, 5'd9});
    check("ld.b addr", {32'd0, bus.data_sram_addr}, 64'h0000_4001);
    bus.ID_EXE_valid = 1'b0;
    tick();

    // st.b under three cycles of MEM back-pressure: exactly one write
    bus.MEM_allow_in = 1'b0;
    drive(0, 32'h0000_1000, 32'd2, 1'b1, 1'b0, 32'h1234_5678, 6'd0, 8'b0100_0000, 32'h1C00_0500);
    tick();
    bus.ID_EXE_valid = 1'b0;
    writes = 0;
    bad    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      writes += int'(bus.data_sram_en);
      if (bus.EXE_MEM_valid !== 1'b1) bad = 1'b1;
      tick();
    end
    check("st.b stall held", {63'd0, bad}, 64'd0);
    check("st.b stall en", 64'(writes), 64'd0);
    bus.MEM_allow_in = 1'b1;
    #1;
    writes += int'(bus.data_sram_en);
    check("st.b release we", {60'd0, bus.data_sram_we}, 64'h4);
    tick();
    writes += int'(bus.data_sram_en);
    check("st.b write count", 64'(writes), 64'd1);
    check("st.b drained", {63'd0, bus.EXE_MEM_valid}, 64'd0);

    // Reset while the divider is at BUSY count 10
    drive(15, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 6'h27, 8'd0, 32'h1C00_0600);
    tick();
    bus.ID_EXE_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-div rst valid", {63'd0, bus.EXE_MEM_valid}, 64'd0);
    check("mid-div rst allow_in", {63'd0, bus.EXE_allow_in}, 64'd1);
    check("mid-div rst not_ready", {63'd0, bus.EXE_rf[38]}, 64'd0);
    drive(0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 6'h23, 8'd0, 32'h1C00_0604);
    tick();
    bus.ID_EXE_valid = 1'b0;
    check("post-rst add valid", {63'd0, bus.EXE_MEM_valid}, 64'd1);
    check("post-rst add result", {32'd0, bus.EXE_to_MEM[31:0]}, 64'd7);
    tick();
    run_div("post-rst div.wu 100/7", 16, 32'd100, 32'd7, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
